// File: rtl/parity_ctrl_pkg.sv
// Shared encodings for the parity counter run/mode controller.
package parity_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_CLEAR = 2'd3;

  localparam logic [1:0] MD_FULL = 2'd0;
  localparam logic [1:0] MD_ODD  = 2'd1;
  localparam logic [1:0] MD_EVEN = 2'd2;

  localparam logic [2:0] LAST_FULL = 3'd7;
  localparam logic [2:0] LAST_ODD  = 3'd7;
  localparam logic [2:0] LAST_EVEN = 3'd6;

  // Final count value of one sequence; Q equal to it on a tick is a wrap.
  function automatic logic [2:0] last_value(input logic [1:0] mode);
    case (mode)
      MD_ODD:  return LAST_ODD;
      MD_EVEN: return LAST_EVEN;
      default: return LAST_FULL;
    endcase
  endfunction

  function automatic logic [1:0] next_mode(input logic [1:0] mode);
    case (mode)
      MD_FULL: return MD_ODD;
      MD_ODD:  return MD_EVEN;
      default: return MD_FULL;
    endcase
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser with a registered one-cycle rising-edge pulse.
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  logic meta_r;
  logic sync_r;
  logic prev_r;
  logic rise_r;

  // Synchronise, delay by one, and register the edge so it lands three edges after the input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      prev_r <= 1'b0;
      rise_r <= 1'b0;
    end else begin
      meta_r <= btn;
      sync_r <= meta_r;
      prev_r <= sync_r;
      rise_r <= sync_r & ~prev_r;
    end
  end

  assign rise = rise_r;

endmodule

// File: rtl/parity_counter_ctrl.sv
// Run/mode controller: conditions buttons, paces the counter with a prescaled
// tick, and optionally auto-advances the mode after a number of wraps.
module parity_counter_ctrl
  import parity_ctrl_pkg::*;
#(
  parameter int TICK_DIV   = 4,
  parameter int WRAP_LIMIT = 2
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       BTN_MODE,
  input  logic       BTN_PAUSE,
  input  logic       BTN_CLEAR,
  input  logic       AUTO,
  input  logic [2:0] Q,
  output logic       EVEN,
  output logic       ODD,
  output logic       PAUSE,
  output logic       RESET,
  output logic [1:0] MODE,
  output logic [1:0] STATE
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int WW = $clog2(WRAP_LIMIT + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [WW-1:0] WRAP_LAST  = WW'(WRAP_LIMIT - 1);

  logic          mode_ev_s, pause_ev_s, clr_ev_s;
  logic          auto_meta_r, auto_sync_r;
  logic [1:0]    state_r, state_next_s;
  logic [1:0]    ret_r, ret_next_s;
  logic [1:0]    mode_r, mode_next_s;
  logic [PW-1:0] presc_r, presc_next_s;
  logic [WW-1:0] wrap_r, wrap_next_s;
  logic          tick_s, wrap_hit_s, auto_ev_s;
  logic          even_r, odd_r, pause_r, reset_r;

  btn_sync_edge u_sync_mode  (.clk(CLK), .rst_n(RESET_N), .btn(BTN_MODE),  .rise(mode_ev_s));
  btn_sync_edge u_sync_pause (.clk(CLK), .rst_n(RESET_N), .btn(BTN_PAUSE), .rise(pause_ev_s));
  btn_sync_edge u_sync_clear (.clk(CLK), .rst_n(RESET_N), .btn(BTN_CLEAR), .rise(clr_ev_s));

  // AUTO is a level, so it only needs the synchroniser.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      auto_meta_r <= 1'b0;
      auto_sync_r <= 1'b0;
    end else begin
      auto_meta_r <= AUTO;
      auto_sync_r <= auto_meta_r;
    end
  end

  // Next-state logic: wrap counting, prescaler and prioritised FSM transitions.
  always_comb begin
    tick_s       = (state_r == ST_RUN) && (presc_r == PRESC_LAST);
    wrap_hit_s   = tick_s && (Q == last_value(mode_r));
    auto_ev_s    = 1'b0;
    wrap_next_s  = wrap_r;
    presc_next_s = presc_r;
    state_next_s = state_r;
    mode_next_s  = mode_r;
    ret_next_s   = ret_r;

    if (!auto_sync_r) begin
      wrap_next_s = '0;
    end else if (wrap_hit_s) begin
      if (wrap_r == WRAP_LAST) begin
        auto_ev_s = 1'b1;
      end else begin
        wrap_next_s = wrap_r + WW'(1);
      end
    end else begin
      wrap_next_s = wrap_r;
    end

    case (state_r)
      ST_CLEAR: begin
        state_next_s = ret_r;
        presc_next_s = '0;
        wrap_next_s  = '0;
      end
      ST_IDLE, ST_RUN, ST_HOLD: begin
        if (state_r == ST_RUN) begin
          presc_next_s = tick_s ? '0 : presc_r + PW'(1);
        end else begin
          presc_next_s = presc_r;
        end
        // A dropped auto event leaves the wrap count where it stands.
        if (clr_ev_s) begin
          state_next_s = ST_CLEAR;
          ret_next_s   = state_r;
        end else if (mode_ev_s) begin
          mode_next_s  = next_mode(mode_r);
          state_next_s = ST_CLEAR;
          ret_next_s   = state_r;
        end else if (pause_ev_s) begin
          state_next_s = (state_r == ST_RUN) ? ST_HOLD : ST_RUN;
        end else if (auto_ev_s) begin
          mode_next_s  = next_mode(mode_r);
          state_next_s = ST_CLEAR;
          ret_next_s   = state_r;
        end else begin
          state_next_s = state_r;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs, all decoded from next-state values.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r <= ST_IDLE;
      ret_r   <= ST_IDLE;
      mode_r  <= MD_FULL;
      presc_r <= '0;
      wrap_r  <= '0;
      even_r  <= 1'b0;
      odd_r   <= 1'b0;
      pause_r <= 1'b1;
      reset_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      ret_r   <= ret_next_s;
      mode_r  <= mode_next_s;
      presc_r <= presc_next_s;
      wrap_r  <= wrap_next_s;
      even_r  <= (mode_next_s == MD_EVEN);
      odd_r   <= (mode_next_s == MD_ODD);
      pause_r <= !((state_next_s == ST_RUN) && (presc_next_s == PRESC_LAST));
      reset_r <= (state_next_s == ST_CLEAR);
    end
  end

  assign STATE = state_r;
  assign MODE  = mode_r;
  assign EVEN  = even_r;
  assign ODD   = odd_r;
  assign PAUSE = pause_r;
  assign RESET = reset_r;

endmodule

// File: tb/tb_parity_counter_ctrl.sv
// Scoreboard bench: a cycle-level reference model queues expected outputs,
// a monitor on the falling edge pops and compares them.
module tb_parity_counter_ctrl;

  localparam int TICK_DIV   = 4;
  localparam int WRAP_LIMIT = 2;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       BTN_MODE = 1'b0, BTN_PAUSE = 1'b0, BTN_CLEAR = 1'b0, AUTO = 1'b0;
  logic [2:0] Q;
  logic       EVEN, ODD, PAUSE, RESET;
  logic [1:0] MODE, STATE;
  logic [7:0] outs;
  logic       q_rand = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];

  int m_st, m_md, m_ret, m_presc, m_wcnt;
  bit hm[1:4], hp[1:4], hc[1:4], ha[1:2];

  parity_counter_ctrl #(.TICK_DIV(TICK_DIV), .WRAP_LIMIT(WRAP_LIMIT)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .BTN_MODE(BTN_MODE), .BTN_PAUSE(BTN_PAUSE),
    .BTN_CLEAR(BTN_CLEAR), .AUTO(AUTO), .Q(Q), .EVEN(EVEN), .ODD(ODD),
    .PAUSE(PAUSE), .RESET(RESET), .MODE(MODE), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  assign outs = {STATE, MODE, EVEN, ODD, PAUSE, RESET};

  // Expected {STATE, MODE, EVEN, ODD, PAUSE, RESET}
  function automatic logic [7:0] pack_exp(int st, int md, int presc);
    logic [1:0] s2, m2;
    s2 = st[1:0];
    m2 = md[1:0];
    return {s2, m2, md == 2, md == 1, !(st == 1 && presc == TICK_DIV - 1), st == 3};
  endfunction

  function automatic logic [2:0] next_q(logic [2:0] q, logic [1:0] md);
    case (md)
      2'd1:    return ((q | 3'd1) == 3'd7) ? 3'd1 : (q | 3'd1) + 3'd2;
      2'd2:    return ((q & 3'd6) == 3'd6) ? 3'd0 : (q & 3'd6) + 3'd2;
      default: return q + 3'd1;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Stand-in counter feeding Q: steps on PAUSE low, clears on RESET, or random values.
  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)       Q <= 3'd0;
    else if (q_rand)    Q <= 3'($urandom_range(0, 7));
    else if (RESET)     Q <= ODD ? 3'd1 : 3'd0;
    else if (!PAUSE)    Q <= next_q(Q, MODE);
  end

  // Reference model: a button seen high at edge n-3 and low at n-4 acts at edge n.
  always @(posedge CLK or negedge RESET_N) begin
    bit ev_m, ev_p, ev_c, au, tick, hit, aev;
    int last;
    if (!RESET_N) begin
      m_st = 0; m_md = 0; m_ret = 0; m_presc = 0; m_wcnt = 0;
      for (int i = 1; i <= 4; i++) begin hm[i] = 0; hp[i] = 0; hc[i] = 0; end
      ha[1] = 0; ha[2] = 0;
      exp_q.delete();
      exp_q.push_back(pack_exp(0, 0, 0));
    end else begin
      ev_m = hm[3] && !hm[4];
      ev_p = hp[3] && !hp[4];
      ev_c = hc[3] && !hc[4];
      au   = ha[2];
      for (int i = 4; i > 1; i--) begin hm[i] = hm[i-1]; hp[i] = hp[i-1]; hc[i] = hc[i-1]; end
      hm[1] = BTN_MODE; hp[1] = BTN_PAUSE; hc[1] = BTN_CLEAR;
      ha[2] = ha[1]; ha[1] = AUTO;

      tick = (m_st == 1) && (m_presc == TICK_DIV - 1);
      last = (m_md == 2) ? 6 : 7;
      hit  = tick && (int'(Q) == last);
      aev  = 0;
      if (!au) m_wcnt = 0;
      else if (hit) begin
        if (m_wcnt == WRAP_LIMIT - 1) aev = 1;
        else m_wcnt = m_wcnt + 1;
      end

      if (m_st == 3) begin
        m_st = m_ret; m_presc = 0; m_wcnt = 0;
      end else begin
        if (m_st == 1) m_presc = (m_presc + 1) % TICK_DIV;
        if (ev_c) begin
          m_ret = m_st; m_st = 3;
        end else if (ev_m || (!ev_p && aev)) begin
          m_md = (m_md + 1) % 3; m_ret = m_st; m_st = 3;
        end else if (ev_p) begin
          m_st = (m_st == 1) ? 2 : 1;
        end
      end
      exp_q.push_back(pack_exp(m_st, m_md, m_presc));
    end
  end

  // Monitor: compare every cycle away from the active edge.
  always @(negedge CLK) begin
    logic [7:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got %b expected %b (STATE MODE EVEN ODD PAUSE RESET)", $time, outs, e);
      end
    end
  end

  task automatic pulse(input bit m, input bit p, input bit c);
    @(posedge CLK); #2;
    BTN_MODE = m; BTN_PAUSE = p; BTN_CLEAR = c;
    @(posedge CLK); #2;
    BTN_MODE = 1'b0; BTN_PAUSE = 1'b0; BTN_CLEAR = 1'b0;
  endtask

  initial begin
    int lows, q6, got, rsts;
    repeat (3) @(posedge CLK);
    #2 RESET_N = 1'b1;
    repeat (5) @(negedge CLK);
    chk("idle_outputs", int'(outs), 8'h02);

    // Start, pacing, hold
    pulse(1'b0, 1'b1, 1'b0);
    repeat (2) @(posedge CLK);
    @(negedge CLK) chk("start_before", int'(STATE), 0);
    @(negedge CLK) chk("start_state", int'(STATE), 1);
    lows = 0;
    for (int i = 0; i < 16; i++) begin @(negedge CLK); if (!PAUSE) lows++; end
    chk("pace_lows", lows, 4);
    pulse(1'b0, 1'b1, 1'b0);
    repeat (3) @(posedge CLK);
    @(negedge CLK) chk("hold_state", int'(STATE), 2);
    lows = 0;
    for (int i = 0; i < 8; i++) begin @(negedge CLK); if (!PAUSE) lows++; end
    chk("hold_pause_lows", lows, 0);

    // Mode advance from RUN
    pulse(1'b0, 1'b1, 1'b0);
    repeat (3) @(posedge CLK);
    pulse(1'b1, 1'b0, 1'b0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("mode1_mode", int'(MODE), 1);
    chk("mode1_odd", int'(ODD), 1);
    chk("mode1_state", int'(STATE), 3);
    chk("mode1_reset", int'(RESET), 1);
    @(negedge CLK);
    chk("mode1_back_state", int'(STATE), 1);
    chk("mode1_reset_drop", int'(RESET), 0);
    pulse(1'b1, 1'b0, 1'b0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("mode2_mode", int'(MODE), 2);
    chk("mode2_even", int'(EVEN), 1);

    // CLEAR and MODE together: clear wins, mode unchanged
    pulse(1'b1, 1'b0, 1'b1);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("simul_state", int'(STATE), 3);
    chk("simul_mode", int'(MODE), 2);
    @(negedge CLK) chk("simul_back", int'(STATE), 1);

    // Auto cycling in EVEN mode
    @(posedge CLK); #2 AUTO = 1'b1;
    pulse(1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge CLK);
    q6 = 0; got = 0;
    for (int i = 0; i < 80 && got == 0; i++) begin
      @(negedge CLK);
      if (MODE == 2'd0) begin
        got = 1;
        chk("auto_reset_pulse", int'(RESET), 1);
      end else if (!PAUSE && Q == 3'd6) begin
        q6++;
      end
    end
    chk("auto_hit", got, 1);
    chk("auto_q6_ticks", q6, 2);
    lows = 0; rsts = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (!PAUSE) lows++;
      if (RESET) rsts++;
    end
    chk("auto_resume_lows", lows, 3);
    chk("auto_single_reset", rsts, 0);
    chk("auto_resume_state", int'(STATE), 1);

    // Asynchronous reset between edges while running
    @(posedge CLK); #3 RESET_N = 1'b0;
    #1 chk("async_reset_outputs", int'(outs), 8'h02);
    AUTO = 1'b0;
    repeat (2) @(posedge CLK);
    #2 RESET_N = 1'b1;

    // Randomised traffic against the model
    for (int i = 0; i < 2500; i++) begin
      @(posedge CLK); #2;
      if ($urandom_range(0, 11) == 0)  BTN_PAUSE = ~BTN_PAUSE;
      if ($urandom_range(0, 29) == 0)  BTN_MODE  = ~BTN_MODE;
      if ($urandom_range(0, 59) == 0)  BTN_CLEAR = ~BTN_CLEAR;
      if ($urandom_range(0, 149) == 0) AUTO      = ~AUTO;
      if ($urandom_range(0, 199) == 0) q_rand    = ~q_rand;
    end
    BTN_PAUSE = 1'b0; BTN_MODE = 1'b0; BTN_CLEAR = 1'b0;
    repeat (10) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
